// File: rtl/fft_pkg.sv
// Shared definitions for the in-place radix-2 DIT FFT sequencing blocks.
//   - Default transform size and component widths.
//   - Complex-word widths ({re,im} packed, re in the upper half).
//   - Sequencer FSM state encoding.
//   - Twiddle-index helper used by the address generator.
package fft_pkg;

  localparam int FFT_LOG2N           = 10;
  localparam int FFT_N_POINTS        = 1 << FFT_LOG2N;
  localparam int FFT_DATA_WIDTH      = 24;
  localparam int FFT_TWIDDLE_WIDTH   = 24;
  localparam int FFT_BFLY_LATENCY    = 3;
  localparam int FFT_CWORD_WIDTH     = 2 * FFT_DATA_WIDTH;
  localparam int FFT_TW_CWORD_WIDTH  = 2 * FFT_TWIDDLE_WIDTH;

  // Default-size complex words.
  typedef logic [FFT_CWORD_WIDTH-1:0]    fft_cword_t;
  typedef logic [FFT_TW_CWORD_WIDTH-1:0] fft_tw_cword_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fft_state_t;

  // Twiddle ROM index for butterfly position pos within stage s of a
  // 2**log2n-point transform: W^(pos * N / (2*span)).
  function automatic int unsigned fft_twiddle_index(
    input int unsigned pos,
    input int unsigned s,
    input int unsigned log2n
  );
    return pos << (log2n - 1 - s);
  endfunction

endpackage

// File: rtl/fft_stage_sequencer_if.sv
// Bus bundle between the FFT stage sequencer and its data RAM, twiddle ROM
// and butterfly pipeline.
//   master : sequencer side (issues reads, operands and write-backs)
//   slave  : RAM / ROM / butterfly side
// Signals:
//   rd_en, rd_addr_a/b, rd_data_a/b : dual-port RAM read, 1-cycle latency
//   tw_addr, twiddle                : twiddle ROM, 1-cycle latency
//   bf_start, bf_data_a/b, bf_twiddle : operands to the butterfly
//   bf_res_a/b, bf_valid            : results from the butterfly
//   wr_en, wr_addr_a/b, wr_data_a/b : dual-port RAM write-back
interface fft_stage_sequencer_if import fft_pkg::*; #(
  parameter int LOG2N         = FFT_LOG2N,
  parameter int DATA_WIDTH    = FFT_DATA_WIDTH,
  parameter int TWIDDLE_WIDTH = FFT_TWIDDLE_WIDTH
) ();

  logic                         rd_en;
  logic [LOG2N-1:0]             rd_addr_a;
  logic [LOG2N-1:0]             rd_addr_b;
  logic [2*DATA_WIDTH-1:0]      rd_data_a;
  logic [2*DATA_WIDTH-1:0]      rd_data_b;
  logic [LOG2N-2:0]             tw_addr;
  logic [2*TWIDDLE_WIDTH-1:0]   twiddle;

  logic                         bf_start;
  logic [2*DATA_WIDTH-1:0]      bf_data_a;
  logic [2*DATA_WIDTH-1:0]      bf_data_b;
  logic [2*TWIDDLE_WIDTH-1:0]   bf_twiddle;
  logic [2*DATA_WIDTH-1:0]      bf_res_a;
  logic [2*DATA_WIDTH-1:0]      bf_res_b;
  logic                         bf_valid;

  logic                         wr_en;
  logic [LOG2N-1:0]             wr_addr_a;
  logic [LOG2N-1:0]             wr_addr_b;
  logic [2*DATA_WIDTH-1:0]      wr_data_a;
  logic [2*DATA_WIDTH-1:0]      wr_data_b;

  modport master (
    output rd_en, rd_addr_a, rd_addr_b, tw_addr,
    input  rd_data_a, rd_data_b, twiddle,
    output bf_start, bf_data_a, bf_data_b, bf_twiddle,
    input  bf_res_a, bf_res_b, bf_valid,
    output wr_en, wr_addr_a, wr_addr_b, wr_data_a, wr_data_b
  );

  modport slave (
    input  rd_en, rd_addr_a, rd_addr_b, tw_addr,
    output rd_data_a, rd_data_b, twiddle,
    input  bf_start, bf_data_a, bf_data_b, bf_twiddle,
    output bf_res_a, bf_res_b, bf_valid,
    input  wr_en, wr_addr_a, wr_addr_b, wr_data_a, wr_data_b
  );

endinterface

// File: rtl/fft_addr_gen.sv
// Radix-2 DIT butterfly address generator (purely combinational).
// Ports:
//   stage  : stage index s (0 .. LOG2N-1)
//   j      : butterfly index within the stage (0 .. N/2-1)
//   addr_a : upper-leg RAM address
//   addr_b : lower-leg RAM address (addr_a + 2**s)
//   tw     : twiddle ROM index
module fft_addr_gen import fft_pkg::*; #(
  parameter int LOG2N = FFT_LOG2N
) (
  input  logic [$clog2(LOG2N)-1:0] stage,
  input  logic [LOG2N-2:0]         j,
  output logic [LOG2N-1:0]         addr_a,
  output logic [LOG2N-1:0]         addr_b,
  output logic [LOG2N-2:0]         tw
);

  int unsigned      s_int;
  logic [LOG2N-1:0] j_ext;
  logic [LOG2N-1:0] span;
  logic [LOG2N-1:0] pos;
  logic [LOG2N-1:0] grp;

  always_comb begin
    s_int  = 32'(stage);
    j_ext  = {1'b0, j};
    span   = LOG2N'(1) << s_int;
    pos    = j_ext & (span - LOG2N'(1));
    grp    = j_ext >> s_int;
    // Open a one-bit gap at position s so that the pair is (addr_a, addr_a+span).
    addr_a = (grp << (s_int + 1)) | pos;
    addr_b = addr_a + span;
    tw     = (LOG2N-1)'(fft_twiddle_index(32'(pos), s_int, LOG2N));
  end

endmodule

// File: rtl/fft_stage_sequencer.sv
// In-place radix-2 DIT FFT stage sequencer.
// Walks LOG2N stages of N/2 butterflies over an external dual-port RAM:
// issues reads and twiddle lookups, forwards operands to the butterfly
// pipeline, and writes its results back to the same addresses. A stage
// only starts once every write of the previous stage has been issued.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   i_start      : start pulse, ignored while busy
//   o_busy       : high from start acceptance until completion
//   o_done       : one-cycle completion pulse
//   o_stage      : current stage index
//   o_err        : sticky, butterfly result seen with nothing in flight
//   bus          : RAM / ROM / butterfly bundle (master side)
module fft_stage_sequencer import fft_pkg::*; #(
  parameter int N_POINTS      = FFT_N_POINTS,
  parameter int LOG2N         = FFT_LOG2N,
  parameter int DATA_WIDTH    = FFT_DATA_WIDTH,
  parameter int TWIDDLE_WIDTH = FFT_TWIDDLE_WIDTH,
  parameter int BFLY_LATENCY  = FFT_BFLY_LATENCY
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      i_start,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [$clog2(LOG2N)-1:0]  o_stage,
  output logic                      o_err,
  fft_stage_sequencer_if.master     bus
);

  localparam int HALF  = N_POINTS / 2;
  localparam int SW    = $clog2(LOG2N);
  localparam int JW    = LOG2N - 1;
  localparam int DEPTH = 1 + BFLY_LATENCY;
  localparam int CNTW  = $clog2(BFLY_LATENCY + 3);
  localparam int AW2   = 2 * LOG2N;

  fft_state_t       state_reg, state_next;
  logic [SW-1:0]    stage_reg, stage_next;
  logic [JW-1:0]    j_reg, j_next;
  logic [CNTW-1:0]  inflight_reg, inflight_next;

  logic             rd_en;
  logic [LOG2N-1:0] gen_addr_a, gen_addr_b;
  logic [JW-1:0]    gen_tw;

  logic                        bf_start_reg;
  logic                        bf_accept, bf_orphan;
  logic                        wr_en_reg;
  logic [LOG2N-1:0]            wr_addr_a_reg, wr_addr_b_reg;
  logic [2*DATA_WIDTH-1:0]     wr_data_a_reg, wr_data_b_reg;
  logic [2*TWIDDLE_WIDTH-1:0]  twiddle_word;
  logic                        err_reg;

  fft_addr_gen #(.LOG2N(LOG2N)) u_addr_gen (
    .stage  (stage_reg),
    .j      (j_reg),
    .addr_a (gen_addr_a),
    .addr_b (gen_addr_b),
    .tw     (gen_tw)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      stage_reg <= '0;
      j_reg     <= '0;
    end else begin
      state_reg <= state_next;
      stage_reg <= stage_next;
      j_reg     <= j_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    stage_next = stage_reg;
    j_next     = j_reg;
    case (state_reg)
      ST_IDLE: begin
        if (i_start) begin
          state_next = ST_RUN;
          stage_next = '0;
          j_next     = '0;
        end
      end
      ST_RUN: begin
        if (j_reg == JW'(HALF - 1)) begin
          state_next = ST_DRAIN;
          j_next     = '0;
        end else begin
          j_next = j_reg + JW'(1);
        end
      end
      ST_DRAIN: begin
        // Leave on the cycle of the last write so the next stage's first
        // read lands exactly one cycle later.
        if (inflight_next == '0) begin
          if (stage_reg == SW'(LOG2N - 1)) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_RUN;
            stage_next = stage_reg + SW'(1);
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
        stage_next = '0;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign rd_en   = (state_reg == ST_RUN);
  assign o_busy  = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
  assign o_done  = (state_reg == ST_DONE);
  assign o_stage = stage_reg;

  // ---------------- read / operand issue ----------------
  assign bus.rd_en     = rd_en;
  assign bus.rd_addr_a = rd_en ? gen_addr_a : '0;
  assign bus.rd_addr_b = rd_en ? gen_addr_b : '0;
  assign bus.tw_addr   = rd_en ? gen_tw     : '0;

  // RAM and ROM data arrive one cycle after the read, aligned with bf_start.
  assign twiddle_word   = bus.twiddle;
  assign bus.bf_start   = bf_start_reg;
  assign bus.bf_data_a  = bus.rd_data_a;
  assign bus.bf_data_b  = bus.rd_data_b;
  assign bus.bf_twiddle = twiddle_word;

  // ---------------- in-flight accounting ----------------
  always_comb begin
    inflight_next = inflight_reg;
    case ({rd_en, wr_en_reg})
      2'b10:   inflight_next = inflight_reg + CNTW'(1);
      2'b01:   inflight_next = inflight_reg - CNTW'(1);
      default: inflight_next = inflight_reg;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) inflight_reg <= '0;
    else          inflight_reg <= inflight_next;
  end

  // ---------------- address delay line ----------------
  // Carries {addr_a, addr_b} from read issue to the butterfly valid cycle.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_dly
    logic [AW2-1:0] q;
    logic [AW2-1:0] d;
    if (gi == 0) begin : g_src
      assign d = {bus.rd_addr_a, bus.rd_addr_b};
    end else begin : g_tap
      assign d = g_dly[gi-1].q;
    end
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) q <= '0;
      else          q <= d;
    end
  end

  // ---------------- write-back ----------------
  // A result with nothing outstanding cannot belong to any read; drop it.
  assign bf_accept = bus.bf_valid && (inflight_reg != '0);
  assign bf_orphan = bus.bf_valid && (inflight_reg == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bf_start_reg  <= 1'b0;
      wr_en_reg     <= 1'b0;
      wr_addr_a_reg <= '0;
      wr_addr_b_reg <= '0;
      wr_data_a_reg <= '0;
      wr_data_b_reg <= '0;
      err_reg       <= 1'b0;
    end else begin
      bf_start_reg <= rd_en;
      wr_en_reg    <= bf_accept;
      if (bf_accept) begin
        {wr_addr_a_reg, wr_addr_b_reg} <= g_dly[DEPTH-1].q;
        wr_data_a_reg <= bus.bf_res_a;
        wr_data_b_reg <= bus.bf_res_b;
      end
      if (bf_orphan) err_reg <= 1'b1;
    end
  end

  assign bus.wr_en     = wr_en_reg;
  assign bus.wr_addr_a = wr_addr_a_reg;
  assign bus.wr_addr_b = wr_addr_b_reg;
  assign bus.wr_data_a = wr_data_a_reg;
  assign bus.wr_data_b = wr_data_b_reg;
  assign o_err         = err_reg;

endmodule
